mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the data bus and the instruction word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: width of the memory address and the PC.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum wait for i_mem_ack, in cycles; legal range 1..255.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_mem_action  in  2  decoder command: 00 pause, 01 read, 10 write, 11 treated as pause.
REQ-008 i_mem_addr_source  in  1  address select: 0 = PC, 1 = AR.
REQ-009 i_pc_counter_en  in  1  increment the PC when this access completes.
REQ-010 i_ar  in  ADDR_WIDTH  address register value.
REQ-011 i_wdata  in  DATA_WIDTH  store data from the selected core register.
REQ-012 o_busy  out  1  access in flight; the decoder holds its command while this is high.
REQ-013 o_pc  out  ADDR_WIDTH  program counter.
REQ-014 o_rdata  out  DATA_WIDTH  last read data, held until the next read completes.
REQ-015 o_rdata_valid  out  1  one-cycle pulse when o_rdata has been updated.
REQ-016 o_err  out  1  one-cycle pulse when an access times out.
REQ-017 o_mem_req  out  1  memory request.
REQ-018 o_mem_we  out  1  1 = write, 0 = read.
REQ-019 o_mem_addr  out  ADDR_WIDTH  memory address.
REQ-020 o_mem_wdata  out  DATA_WIDTH  memory write data.
REQ-021 i_mem_ack  in  1  memory completion; read data on i_mem_rdata is valid in the same cycle.
REQ-022 i_mem_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-023 SHALL implement a state machine with states IDLE and WAIT.
REQ-024 In IDLE with action read or write, SHALL at the clock edge:
- latch the address (PC if source = 0, else i_ar), the write-enable, i_wdata and i_pc_counter_en;
- go to WAIT;
- clear the timeout counter.
REQ-025 In IDLE with action pause or 11, SHALL stay in IDLE and leave all registers unchanged.
REQ-026 All outputs SHALL be registered; o_mem_req and o_busy SHALL be 1 exactly while the state is WAIT, starting the cycle after acceptance.
REQ-027 o_mem_addr, o_mem_we and o_mem_wdata SHALL hold the latched values, stable for the whole of WAIT.
REQ-028 In WAIT with i_mem_ack = 1, SHALL return to IDLE at the next edge, completing the access.
REQ-029 On a completed read, SHALL load o_rdata from i_mem_rdata and pulse o_rdata_valid for one cycle; on a completed write, o_rdata SHALL be unchanged.
REQ-030 On completion with the latched pc-increment flag set and the latched source = PC, SHALL load o_pc with o_pc+1 modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
REQ-031 The PC SHALL never change except under REQ-030; an increment flag with source AR SHALL be ignored.
REQ-032 In WAIT without ack, SHALL increment the timeout counter each cycle.
REQ-033 When the timeout counter reaches TIMEOUT with no ack, SHALL:
- return to IDLE;
- pulse o_err for one cycle;
- leave o_pc and o_rdata unchanged.
REQ-034 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win: normal completion, no o_err.
REQ-035 Commands presented while in WAIT SHALL be ignored; i_mem_ack while in IDLE SHALL be ignored.
REQ-036 Back-to-back: a new command SHALL be accepted in the IDLE cycle immediately following completion, giving a minimum of 2 cycles per access.

Reset
REQ-037 While rst_n = 0, SHALL asynchronously force: state IDLE, o_pc = 0, o_rdata = 0, all latches and the timeout counter = 0, and every output = 0.
REQ-038 Reset asserted during WAIT SHALL abort the access with no o_err, no PC change and no rdata update; after release, the first edge SHALL sample commands from IDLE.

Verification
REQ-039 Reset, then read from PC with increment, ack on the 3rd WAIT cycle with rdata 0xA5 -> o_mem_addr = 0x00 and o_mem_we = 0 while requesting; o_rdata = 0xA5 with one valid pulse; o_pc = 0x01.
REQ-040 Write from AR, i_ar = 0x40, i_wdata = 0x3C, immediate ack -> o_mem_req high 1 cycle, o_mem_we = 1, addr 0x40, wdata 0x3C; o_pc and o_rdata unchanged.
REQ-041 PC = 0xFF, read with increment, ack -> o_pc = 0x00.
REQ-042 Read with no ack, TIMEOUT = 15 -> o_mem_req high exactly 15 cycles, one o_err pulse, o_pc unchanged; ack arriving on cycle 15 instead -> completion, no o_err.
REQ-043 i_mem_action and i_ar changed while in WAIT -> o_mem_addr unchanged and no second request; stray ack in IDLE -> no outputs change.
REQ-044 rst_n low mid-WAIT, asynchronous to clk -> o_mem_req and o_busy drop immediately; o_pc = 0; no o_rdata_valid or o_err pulse.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a decoder read/write command into a single
// request/acknowledge transaction on the memory port. It owns the program
// counter, keeps the most recent read data, and gives up on an access
// after TIMEOUT cycles without an acknowledge.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no access in flight; sample the decoder command every edge
// S_WAIT | request driven with latched address/data; wait for ack
module mem_access_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_mem_action,
    input  logic                  i_mem_addr_source,
    input  logic                  i_pc_counter_en,
    input  logic [ADDR_WIDTH-1:0] i_ar,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rdata_valid,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The counter is cleared on acceptance and advanced once per WAIT cycle
    // without ack, so it equals TIMEOUT-1 during the TIMEOUT-th WAIT cycle;
    // that cycle is the last one in which an ack can still win.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  inc_q, inc_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  cmd_access;

    assign cmd_access = (i_mem_action == 2'b01) || (i_mem_action == 2'b10);

    // Next-state and next-register computation for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        inc_d   = inc_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_access) begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    addr_d  = i_mem_addr_source ? i_ar : pc_q;
                    we_d    = (i_mem_action == 2'b10);
                    wdata_d = i_wdata;
                    // An increment request only matters for PC-sourced
                    // accesses, so fold the source into the latched flag.
                    inc_d   = i_pc_counter_en & ~i_mem_addr_source;
                end
            end
            S_WAIT: begin
                if (i_mem_ack) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = i_mem_rdata;
                        valid_d = 1'b1;
                    end
                    if (inc_q) begin
                        pc_d = pc_q + PC_ONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_mem_req     = busy_q;
    assign o_pc          = pc_q;
    assign o_rdata       = rdata_q;
    assign o_rdata_valid = valid_q;
    assign o_err         = err_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, and a random phase.
module tb_mem_access_unit;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    i_mem_action = '0;
    logic          i_mem_addr_source = 1'b0;
    logic          i_pc_counter_en = 1'b0;
    logic [AW-1:0] i_ar = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          i_mem_ack = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_busy, o_rdata_valid, o_err, o_mem_req, o_mem_we;
    logic [AW-1:0] o_pc, o_mem_addr;
    logic [DW-1:0] o_rdata, o_mem_wdata;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_action(i_mem_action), .i_mem_addr_source(i_mem_addr_source),
        .i_pc_counter_en(i_pc_counter_en), .i_ar(i_ar), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_pc(o_pc), .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending-access record plus elapsed WAIT cycles.
    bit            m_active;
    int            m_elapsed;
    logic [AW-1:0] m_addr, m_pc;
    logic [DW-1:0] m_wdata, m_rdata;
    bit            m_we, m_bump_pc, m_valid, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_elapsed = 0; m_addr = '0; m_pc = '0;
            m_wdata = '0; m_rdata = '0; m_we = 0; m_bump_pc = 0;
            m_valid = 0; m_err = 0;
        end else begin
            m_valid = 0;
            m_err   = 0;
            if (!m_active) begin
                if (i_mem_action == 2'd1 || i_mem_action == 2'd2) begin
                    m_active  = 1;
                    m_elapsed = 0;
                    m_addr    = i_mem_addr_source ? i_ar : m_pc;
                    m_we      = (i_mem_action == 2'd2);
                    m_wdata   = i_wdata;
                    m_bump_pc = i_pc_counter_en && !i_mem_addr_source;
                end
            end else begin
                m_elapsed++;
                if (i_mem_ack) begin
                    m_active = 0;
                    if (!m_we) begin
                        m_rdata = i_mem_rdata;
                        m_valid = 1;
                    end
                    if (m_bump_pc) m_pc = AW'((int'(m_pc) + 1) % (1 << AW));
                end else if (m_elapsed == TO) begin
                    m_active = 0;
                    m_err    = 1;
                end
            end
        end
    end

    int req_cycles = 0;
    int valid_pulses = 0;
    int err_pulses = 0;

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("busy", o_busy, m_active);
        chk("mem_req", o_mem_req, m_active);
        chk("mem_we", o_mem_we, m_we);
        chk("mem_addr", o_mem_addr, m_addr);
        chk("mem_wdata", o_mem_wdata, m_wdata);
        chk("pc", o_pc, m_pc);
        chk("rdata", o_rdata, m_rdata);
        chk("rdata_valid", o_rdata_valid, m_valid);
        chk("err", o_err, m_err);
        if (o_mem_req) req_cycles++;
        if (o_rdata_valid) valid_pulses++;
        if (o_err) err_pulses++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [AW-1:0] first_addr;
    logic          first_we;
    logic [DW-1:0] first_wdata;

    // One access: command for one cycle, ack at WAIT cycle ack_at (0 = never).
    task automatic access(input logic [1:0] act, input logic src, input logic inc,
                          input logic [AW-1:0] ar, input logic [DW-1:0] wd,
                          input int ack_at, input logic [DW-1:0] rd, input bit disturb);
        int limit;
        req_cycles = 0; valid_pulses = 0; err_pulses = 0;
        i_mem_action = act; i_mem_addr_source = src; i_pc_counter_en = inc;
        i_ar = ar; i_wdata = wd; i_mem_ack = 0;
        step();
        first_addr = o_mem_addr; first_we = o_mem_we; first_wdata = o_mem_wdata;
        i_mem_action = 2'd0;
        limit = (ack_at > 0) ? ack_at : TO;
        for (int n = 1; n <= limit; n++) begin
            if (disturb && n < limit) begin
                i_mem_action = 2'($urandom_range(1, 2));
                i_ar = AW'($urandom);
                i_mem_addr_source = 1'($urandom);
            end else begin
                i_mem_action = 2'd0;
            end
            if (n == ack_at) begin
                i_mem_ack = 1'b1;
                i_mem_rdata = rd;
            end
            step();
            i_mem_ack = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        step(); step();
        chk("reset_pc", o_pc, 8'h00);
        chk("reset_req", o_mem_req, 1'b0);
        chk("reset_rdata", o_rdata, 8'h00);
        rst_n = 1'b1;
        step();

        // Read from PC with increment, ack on 3rd WAIT cycle.
        access(2'd1, 1'b0, 1'b1, 8'h00, 8'h00, 3, 8'hA5, 0);
        chk("t039_addr", first_addr, 8'h00);
        chk("t039_we", first_we, 1'b0);
        chk("t039_req_cycles", req_cycles, 3);
        chk("t039_rdata", o_rdata, 8'hA5);
        chk("t039_valid", o_rdata_valid, 1'b1);
        chk("t039_pc", o_pc, 8'h01);
        step();
        chk("t039_valid_pulses", valid_pulses, 1);

        // Write from AR, immediate ack.
        access(2'd2, 1'b1, 1'b1, 8'h40, 8'h3C, 1, 8'h99, 0);
        chk("t040_addr", first_addr, 8'h40);
        chk("t040_we", first_we, 1'b1);
        chk("t040_wdata", first_wdata, 8'h3C);
        chk("t040_req_cycles", req_cycles, 1);
        chk("t040_pc", o_pc, 8'h01);
        chk("t040_rdata", o_rdata, 8'hA5);
        step();
        chk("t040_valid_pulses", valid_pulses, 0);

        // Timeout, then ack on the last allowed cycle.
        access(2'd1, 1'b0, 1'b1, 8'h00, 8'h00, 0, 8'h00, 0);
        chk("t042_req_cycles", req_cycles, 15);
        chk("t042_err", o_err, 1'b1);
        chk("t042_pc", o_pc, 8'h01);
        step();
        chk("t042_err_pulses", err_pulses, 1);
        access(2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 15, 8'h5A, 0);
        chk("t042b_req_cycles", req_cycles, 15);
        chk("t042b_rdata", o_rdata, 8'h5A);
        step();
        chk("t042b_err_pulses", err_pulses, 0);

        // Commands changing during WAIT; then stray ack in IDLE.
        access(2'd1, 1'b1, 1'b0, 8'h77, 8'h00, 4, 8'h11, 1);
        chk("t043_addr_hold", o_mem_addr, 8'h77);
        chk("t043_req_cycles", req_cycles, 4);
        chk("t043_rdata", o_rdata, 8'h11);
        i_mem_action = 2'd0; i_mem_ack = 1'b1; i_mem_rdata = 8'hEE;
        step();
        req_cycles = 0; valid_pulses = 0; err_pulses = 0;
        step(); step(); step();
        i_mem_ack = 1'b0;
        chk("t043_stray_rdata", o_rdata, 8'h11);
        chk("t043_stray_req", req_cycles, 0);
        chk("t043_stray_valid", valid_pulses, 0);
        chk("t043_stray_pc", o_pc, 8'h01);

        // Walk PC to 0xFF, then wrap.
        guard = 0;
        while (m_pc != 8'hFF && guard < 300) begin
            access(2'd1, 1'b0, 1'b1, 8'h00, 8'h00, 1, 8'($urandom), 0);
            guard++;
        end
        chk("t041_pc_ff", o_pc, 8'hFF);
        access(2'd1, 1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h00, 0);
        chk("t041_pc_wrap", o_pc, 8'h00);

        // Random traffic, short then long ack latencies.
        for (int c = 0; c < 3000; c++) begin
            i_mem_action = 2'($urandom);
            i_mem_addr_source = 1'($urandom);
            i_pc_counter_en = 1'($urandom);
            i_ar = AW'($urandom);
            i_wdata = DW'($urandom);
            i_mem_rdata = DW'($urandom);
            i_mem_ack = ($urandom_range(0, (c < 1500) ? 2 : 19) == 0);
            step();
        end
        i_mem_ack = 1'b0; i_mem_action = 2'd0;
        step();

        // Asynchronous reset in the middle of WAIT.
        access(2'd1, 1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h33, 0);
        i_mem_action = 2'd1; i_mem_addr_source = 1'b0; i_pc_counter_en = 1'b1;
        step();
        i_mem_action = 2'd0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t044_req", o_mem_req, 1'b0);
        chk("t044_busy", o_busy, 1'b0);
        chk("t044_pc", o_pc, 8'h00);
        valid_pulses = 0; err_pulses = 0;
        step(); step();
        rst_n = 1'b1;
        i_mem_action = 2'd1; i_mem_addr_source = 1'b0;
        step();
        i_mem_action = 2'd0;
        chk("t044_restart_req", o_mem_req, 1'b1);
        chk("t044_restart_addr", o_mem_addr, 8'h00);
        chk("t044_no_valid", valid_pulses, 0);
        chk("t044_no_err", err_pulses, 0);
        i_mem_ack = 1'b1; i_mem_rdata = 8'hC3;
        step();
        i_mem_ack = 1'b0;
        chk("t044_done_rdata", o_rdata, 8'hC3);
        chk("t044_done_pc", o_pc, 8'h01);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
